// File: rtl/layer0_input_packer.sv
// rtl/layer0_input_packer.sv - binarise and pack a sample stream into a two-slot buffered M0 vector
//
// Purpose:
//   Takes one signed sample per beat and compares it with that feature's
//   programmable threshold. The resulting bit is packed into an assembly
//   register. A complete vector goes to M0 when the output slot is free.
//   Otherwise it waits in the assembly register, which acts as the second slot.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   s_valid/s_ready    sample stream handshake
//   s_data, s_last     signed sample and end-of-vector marker
//   cfg_we/addr/data   threshold write port (out-of-range addresses ignored)
//   m_valid/m_ready    output vector handshake
//   M0                 packed vector, bit i = feature i
//   err_len            one-cycle pulse on a vector-length error

module layer0_input_packer #(
    parameter int NUM_FEAT = 25,
    parameter int IN_W     = 8,
    parameter int ADDR_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IN_W-1:0] s_data,
    input  logic                   s_last,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic signed [IN_W-1:0] cfg_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [NUM_FEAT-1:0]    M0,
    output logic                   err_len
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_FEAT - 1);
    localparam logic [ADDR_W:0]   NF_EXT   = (ADDR_W + 1)'(NUM_FEAT);

    logic signed [IN_W-1:0] thr [NUM_FEAT];
    logic [ADDR_W-1:0]      idx;
    logic [NUM_FEAT-1:0]    asm;
    logic                   asm_full;

    logic                   beat;
    logic                   feat_bit;
    logic                   at_last;
    logic                   slot_free;
    logic                   out_take;
    logic                   cfg_hit;
    logic [NUM_FEAT-1:0]    done_vec;

    // s_ready looks only at registered state and rst, never at m_ready.
    assign s_ready   = !asm_full && !rst;
    assign beat      = s_valid && s_ready;
    assign feat_bit  = (s_data >= thr[idx]);
    assign at_last   = (idx == LAST_IDX);
    assign out_take  = m_valid && m_ready;
    assign slot_free = !m_valid || m_ready;
    assign cfg_hit   = cfg_we && ({1'b0, cfg_addr} < NF_EXT);

    // The last bit is not registered yet, so splice the live compare into the vector.
    always_comb begin
        done_vec      = asm;
        done_vec[idx] = feat_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            asm      <= '0;
            asm_full <= 1'b0;
            M0       <= '0;
            m_valid  <= 1'b0;
            err_len  <= 1'b0;
            for (int i = 0; i < NUM_FEAT; i++) begin
                thr[i] <= '0;
            end
        end else begin
            err_len <= 1'b0;

            // Drain side. Beats are blocked while asm_full, so the beat branch
            // below cannot overwrite a reload from asm.
            if (out_take) begin
                if (asm_full) begin
                    M0       <= asm;
                    asm_full <= 1'b0;
                end else begin
                    m_valid  <= 1'b0;
                end
            end

            if (beat) begin
                if (at_last) begin
                    idx     <= '0;
                    err_len <= !s_last;
                    if (slot_free) begin
                        // Assigned after the drain branch so a same-cycle handshake refills.
                        M0      <= done_vec;
                        m_valid <= 1'b1;
                        asm     <= '0;
                    end else begin
                        asm      <= done_vec;
                        asm_full <= 1'b1;
                    end
                end else if (s_last) begin
                    idx     <= '0;
                    asm     <= '0;
                    err_len <= 1'b1;
                end else begin
                    asm[idx] <= feat_bit;
                    idx      <= idx + ADDR_W'(1);
                end
            end

            // The compare above reads the old value, so a same-cycle write
            // to the beat's own index does not affect that beat.
            if (cfg_hit) begin
                thr[cfg_addr] <= cfg_data;
            end
        end
    end

endmodule

// File: tb/tb_layer0_input_packer.sv
// tb/tb_layer0_input_packer.sv - randomized self-checking bench with queue-based reference model

module tb_layer0_input_packer;

    localparam int NF = 25;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic signed [7:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              cfg_we = 1'b0;
    logic [4:0]        cfg_addr = '0;
    logic signed [7:0] cfg_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [NF-1:0]     M0;
    logic              err_len;

    int total = 0;
    int bad   = 0;
    bit rnd_mode = 1'b0;

    layer0_input_packer #(.NUM_FEAT(NF), .IN_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .m_valid(m_valid), .m_ready(m_ready), .M0(M0),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    // Reference model: the output side is a queue of at most two vectors.
    // The head is M0, and a second entry means the packer is full.
    bit [NF-1:0]       outq[$];
    bit [NF-1:0]       cur;
    int                n;
    bit                err_m;
    logic signed [7:0] thr_m [NF];
    bit                m_acc;
    bit                m_bit;

    initial begin
        n = 0; cur = '0; err_m = 1'b0;
        for (int i = 0; i < NF; i++) thr_m[i] = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            outq.delete();
            n = 0; cur = '0; err_m = 1'b0;
            for (int i = 0; i < NF; i++) thr_m[i] = '0;
        end else begin
            err_m = 1'b0;
            m_acc = s_valid && (outq.size() < 2);
            if (outq.size() > 0 && m_ready) void'(outq.pop_front());
            if (m_acc) begin
                m_bit = (s_data >= thr_m[n]);
                if (n == NF - 1) begin
                    cur[n] = m_bit;
                    outq.push_back(cur);
                    err_m = !s_last;
                    n = 0; cur = '0;
                end else if (s_last) begin
                    err_m = 1'b1;
                    n = 0; cur = '0;
                end else begin
                    cur[n] = m_bit;
                    n++;
                end
            end
            if (cfg_we && int'(cfg_addr) < NF) thr_m[cfg_addr] = cfg_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        chk("s_ready", {31'b0, s_ready}, {31'b0, (!rst && outq.size() < 2)});
        chk("m_valid", {31'b0, m_valid}, {31'b0, (outq.size() > 0)});
        chk("err_len", {31'b0, err_len}, {31'b0, err_m});
        if (outq.size() > 0) chk("M0", 32'(M0), 32'(outq[0]));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic signed [7:0] d, input bit last,
                             input bit we, input logic [4:0] a, input logic signed [7:0] cd);
        bit acc;
        int waited;
        waited = 0;
        s_valid = 1'b1; s_data = d; s_last = last;
        cfg_we = we; cfg_addr = a; cfg_data = cd;
        forever begin
            @(negedge clk);
            acc = s_ready;
            tick();
            cfg_we = 1'b0;
            if (acc) break;
            if (rnd_mode) m_ready = 1'($urandom_range(0, 1));
            waited++;
            if (waited > 200) begin
                total++; bad++;
                $display("FAIL beat_timeout: got no s_ready expected s_ready within 200 cycles");
                break;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic signed [7:0] cd);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = cd;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send_vec(input logic signed [7:0] d, input int nbeats, input int last_at);
        for (int i = 0; i < nbeats; i++) send_beat(d, (i == last_at), 1'b0, 5'd0, 8'sd0);
    endtask

    initial begin
        int kind, len;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_M0", 32'(M0), 32'h0);
        chk("rst_m_valid", {31'b0, m_valid}, 32'h0);
        chk("rst_s_ready", {31'b0, s_ready}, 32'h0);
        rst = 1'b0;
        tick();

        // Ramp thresholds with zero samples
        for (int i = 0; i < NF; i++) cfg_write(5'(i), 8'(i - 12));
        m_ready = 1'b1;
        send_vec(8'sd0, NF, NF - 1);
        @(negedge clk);
        chk("t1_m_valid", {31'b0, m_valid}, 32'h1);
        chk("t1_M0", 32'(M0), 32'h0001FFF);
        chk("t1_err", {31'b0, err_len}, 32'h0);
        tick();

        // Two-slot back-pressure
        for (int i = 0; i < NF; i++) cfg_write(5'(i), 8'sd0);
        m_ready = 1'b0;
        send_vec(8'sd127, NF, NF - 1);
        send_vec(8'sd127, NF, NF - 1);
        @(negedge clk);
        chk("t2_full_s_ready", {31'b0, s_ready}, 32'h0);
        chk("t2_M0", 32'(M0), 32'h1FFFFFF);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        chk("t2_reload_valid", {31'b0, m_valid}, 32'h1);
        chk("t2_reload_s_ready", {31'b0, s_ready}, 32'h1);
        tick();
        m_ready = 1'b1;
        tick(); tick();

        // Early s_last on beat 9
        send_vec(8'sd5, 10, 9);
        @(negedge clk);
        chk("t3_err_pulse", {31'b0, err_len}, 32'h1);
        tick();
        @(negedge clk);
        chk("t3_err_once", {31'b0, err_len}, 32'h0);
        chk("t3_no_valid", {31'b0, m_valid}, 32'h0);
        tick();
        send_vec(-8'sd3, NF, NF - 1);
        @(negedge clk);
        chk("t3_next_vec", 32'(M0), 32'h0);
        tick();

        // Missing s_last
        send_vec(8'sd1, NF, -1);
        @(negedge clk);
        chk("t4_err", {31'b0, err_len}, 32'h1);
        chk("t4_M0", 32'(M0), 32'h1FFFFFF);
        tick();

        // Boundary compares and same-cycle threshold write
        cfg_write(5'd3, -8'sd128);
        for (int i = 0; i < NF; i++) begin
            if (i == 3) send_beat(-8'sd128, 1'b0, 1'b0, 5'd0, 8'sd0);
            else if (i == 5) send_beat(8'sd0, 1'b0, 1'b1, 5'd5, 8'sd100);
            else send_beat(8'sd0, (i == NF - 1), 1'b0, 5'd0, 8'sd0);
        end
        @(negedge clk);
        chk("t5_min_and_old_thr", 32'(M0), 32'h1FFFFFF);
        tick();
        cfg_write(5'd3, 8'sd127);
        for (int i = 0; i < NF; i++) send_beat((i == 3) ? 8'sd126 : 8'sd0, (i == NF - 1), 1'b0, 5'd0, 8'sd0);
        @(negedge clk);
        chk("t5_max_and_new_thr", 32'(M0), 32'h1FFFFD7);
        tick();

        // Reset mid-vector while holding an output
        for (int i = 0; i < NF; i++) cfg_write(5'(i), 8'sd50);
        m_ready = 1'b0;
        send_vec(8'sd60, NF, NF - 1);
        send_vec(8'sd60, 17, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_m_valid", {31'b0, m_valid}, 32'h0);
        chk("t6_M0", 32'(M0), 32'h0);
        tick();
        m_ready = 1'b1;
        send_vec(8'sd10, NF, NF - 1);
        @(negedge clk);
        chk("t6_thr_zero", 32'(M0), 32'h1FFFFFF);
        tick();

        // Randomized traffic
        rnd_mode = 1'b1;
        for (int v = 0; v < 120; v++) begin
            kind = $urandom_range(0, 7);
            len = (kind == 0) ? $urandom_range(1, NF - 1) : NF;
            for (int i = 0; i < len; i++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) tick();
                send_beat(8'($urandom), (kind != 1) && (i == len - 1),
                          ($urandom_range(0, 5) == 0), 5'($urandom), 8'($urandom));
            end
        end
        rnd_mode = 1'b0;
        m_ready = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer0_input_packer.md
Name: layer0_input_packer

Overview:
- Upstream feeder for the first LogicNets layer.
- Accepts a stream of signed input samples, one feature per beat, and binarises each against a per-feature runtime-programmable threshold.
- Packs the NUM_FEAT bits into the flat M0 vector consumed by layer1.
- Holds M0 stable behind a valid/ready handshake while the next vector is assembled (two-slot buffering).

Parameters:
- NUM_FEAT, 25, features per vector; equals the M0 width of layer1.
- IN_W, 8, signed sample and threshold width.
- ADDR_W, 5, threshold address width; 2**ADDR_W >= NUM_FEAT.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  packer can accept a sample.
- s_data  input  IN_W  signed sample for the current feature index.
- s_last  input  1  marks the final feature of a vector.
- cfg_we  input  1  threshold write strobe.
- cfg_addr  input  ADDR_W  threshold index.
- cfg_data  input  IN_W  signed threshold value.
- m_valid  output  1  M0 holds a complete vector.
- m_ready  input  1  downstream accepts M0.
- M0  output  NUM_FEAT  packed feature bits; bit i = feature i.
- err_len  output  1  one-cycle pulse on a vector-length error.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - idx=0, asm=0, asm_full=0, M0=0, m_valid=0, err_len=0, all thresholds=0.
  - s_ready=0 while rst is high.
- Beat and binarisation:
  - A beat is accepted when s_valid && s_ready.
  - Feature bit = ($signed(s_data) >= $signed(thr[idx])); the comparison is a full IN_W signed compare.
  - The bit is written to asm[idx] and idx increments.
- s_ready = !asm_full && !rst.
- Vector completion, on acceptance of the beat with idx==NUM_FEAT-1:
  - The completed vector is asm with bit idx replaced by the current compare.
  - If the output slot is free (!m_valid, or m_valid && m_ready in the same cycle): M0 <= completed vector and m_valid <= 1 next cycle. Latency is 1 cycle from the last beat to m_valid.
  - Otherwise the vector stays in asm and asm_full <= 1.
  - In both cases idx <= 0.
- asm_full=1:
  - No beats are accepted.
  - On the output handshake (m_valid && m_ready): M0 <= asm, m_valid stays 1, asm_full <= 0.
  - s_ready rises the following cycle.
- Output handshake with asm not full: m_valid <= 0 next cycle.
- M0 is stable whenever m_valid=1 && m_ready=0.
- Sustained throughput is one vector per NUM_FEAT cycles when m_ready=1.
- Length errors:
  - Early s_last (accepted with idx < NUM_FEAT-1): err_len pulses the next cycle, the partial vector is discarded (asm cleared), idx <= 0, and no output is produced.
  - Missing s_last (beat at idx==NUM_FEAT-1 without s_last): err_len pulses, but the vector is still completed and emitted as normal, and idx <= 0.
  - s_last on the correct beat: no error.
- Threshold writes:
  - cfg_we=1 with cfg_addr < NUM_FEAT writes thr[cfg_addr] at the clock edge.
  - Writes with cfg_addr >= NUM_FEAT are ignored.
  - A write takes effect for beats accepted in later cycles.
  - A beat accepted in the same cycle as a write to its own index uses the old threshold.
  - Writes are legal at any time, including mid-vector.
- Reset mid-vector: the partial vector and any buffered or held vector are dropped, and thresholds return to 0.
  - Software must reprogram the thresholds after reset.
- No combinational path from m_ready to s_ready.
  - s_ready depends only on registered asm_full.

Test Plan:
- Reset, then program thr[i]=i-12 for i=0..24. Stream s_data=0 for all 25 beats with s_last on beat 24 and m_ready=1 -> m_valid one cycle after the last beat, M0=25'h1FFF (bits 0..12 set), err_len=0.
- Hold m_ready=0 and stream two full vectors back to back (all samples 127, thr=0) -> the first vector appears on M0=25'h1FFFFFF, asm_full=1 after the second vector, and s_ready=0. Raise m_ready for one cycle -> M0 reloads from asm, s_ready=1 the next cycle, and no beat is lost.
- Assert s_last on beat 9 -> err_len pulses exactly once, no m_valid. The next 25-beat vector is packed from idx 0 correctly.
- Send 25 beats with no s_last -> err_len pulses once, and the vector is still emitted with correct bits.
- Boundary compare: thr[3]=-128, s_data=-128 -> bit 3=1. Then thr[3]=127, s_data=126 -> bit 3=0. A cfg write to thr[5] in the same cycle as feature 5's beat -> the old threshold is applied.
- Assert rst for one cycle at beat 17 while m_valid=1 -> the next cycle has m_valid=0, M0=0, and thresholds=0. The next vector starts at idx 0.
